// File: rtl/game_pkg.sv
// Stone/state types and preset board generator for the board keeper.
// GAME_MOVE_APPLY_EN adds the move-check and move-write states.
package game_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    BLACK = 2'b01,
    WHITE = 2'b10
  } stone_t;

`ifdef GAME_MOVE_APPLY_EN
  typedef enum logic [1:0] {
    SELF,
    RX_WAIT,
    MOVE_CHK,
    MOVE_WR
  } state_t;
`else
  typedef enum logic {
    SELF,
    RX_WAIT
  } state_t;
`endif

  localparam int MAX_N = 19;

  typedef logic [2*MAX_N*MAX_N-1:0] board_max_t;

  // Cell (r,c) occupies bits [2*(r*n+c) +: 2] of a flat board.
  function automatic int cell_lsb(
    input int r,
    input int c,
    input int n
  );
    return 2 * (r * n + c);
  endfunction

  // idx 1 is the corner variant: BLACK on the four corners,
  // WHITE on the centre cell.
  function automatic board_max_t preset_board(
    input int idx,
    input int n
  );
    board_max_t b;
    b = '0;
    case (idx)
      0: begin
        b[cell_lsb(0, 0, n) +: 2]     = WHITE;
        b[cell_lsb(0, 1, n) +: 2]     = BLACK;
        b[cell_lsb(1, 0, n) +: 2]     = BLACK;
        b[cell_lsb(1, 1, n) +: 2]     = BLACK;
        b[cell_lsb(n-2, n-2, n) +: 2] = WHITE;
        b[cell_lsb(n-2, n-1, n) +: 2] = WHITE;
        b[cell_lsb(n-1, n-2, n) +: 2] = WHITE;
        b[cell_lsb(n-1, n-1, n) +: 2] = WHITE;
      end
      1: begin
        b[cell_lsb(0, 0, n) +: 2]       = BLACK;
        b[cell_lsb(0, n-1, n) +: 2]     = BLACK;
        b[cell_lsb(n-1, 0, n) +: 2]     = BLACK;
        b[cell_lsb(n-1, n-1, n) +: 2]   = BLACK;
        b[cell_lsb(n/2, n/2, n) +: 2]   = WHITE;
      end
      default: ;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/move_check.sv
// Combinational legality check for a move: in range and target empty.
// Only instantiated when GAME_MOVE_APPLY_EN is defined.
module move_check
  import game_pkg::*;
#(
  parameter  int N   = 9,
  localparam int RCW = $clog2(N)
) (
  input  logic [2*N*N-1:0] board,
  input  logic [RCW-1:0]   row,
  input  logic [RCW-1:0]   col,
  output logic             legal
);

  always_comb begin
    legal = 1'b0;
    if (int'(row) < N && int'(col) < N) begin
      legal = board[cell_lsb(int'(row), int'(col), N) +: 2] == EMPTY;
    end
  end

endmodule

// File: rtl/board_keeper.sv
// Board keeper: holds a go board from a preset, a remote source or moves.
// Move handling is compiled in only with GAME_MOVE_APPLY_EN defined.
module board_keeper
  import game_pkg::*;
#(
  parameter  int N           = 9,
  parameter  int NUM_PRESETS = 2,
  localparam int RCW         = $clog2(N),
  localparam int PSW         = (NUM_PRESETS > 1) ? $clog2(NUM_PRESETS) : 1
) (
  input  logic               clk_in,
  input  logic               reset,
  input  logic               comm_sel,
  input  logic [PSW-1:0]     preset_sel,
  input  logic               rx_valid,
  output logic               rx_ready,
  input  logic [2*N*N-1:0]   board_in,
  input  logic               move_valid,
  output logic               move_ready,
  input  logic [RCW-1:0]     move_row,
  input  logic [RCW-1:0]     move_col,
  output logic [2*N*N-1:0]   board,
  output logic               turn,
  output logic               board_update,
  output logic               move_err
);

  localparam int BW = 2 * N * N;

  state_t     state_q;
  state_t     state_d;
  logic [BW-1:0] board_q;
  logic [BW-1:0] board_d;
  logic [BW-1:0] preset;
  board_max_t preset_all;
  logic       upd_q;
  logic       upd_d;
  logic       wrote;
  logic       unused_bits;

  always_comb begin
    preset_all = '0;
    if (int'(preset_sel) < NUM_PRESETS) begin
      preset_all = preset_board(int'(preset_sel), N);
    end
  end

  assign preset      = preset_all[BW-1:0];
  assign unused_bits = ^preset_all;

  assign rx_ready     = state_q == RX_WAIT;
  assign board        = board_q;
  assign board_update = upd_q;

`ifdef GAME_MOVE_APPLY_EN
  logic           turn_q;
  logic           turn_d;
  logic           err_q;
  logic           err_d;
  logic           legal;
  logic [RCW-1:0] row_q;
  logic [RCW-1:0] row_d;
  logic [RCW-1:0] col_q;
  logic [RCW-1:0] col_d;

  move_check #(
    .N(N)
  ) u_move_check (
    .board(board_q),
    .row  (row_q),
    .col  (col_q),
    .legal(legal)
  );

  // A remote board offered in the same cycle always beats a move.
  assign move_ready = (state_q == RX_WAIT) && !rx_valid && comm_sel;
  assign turn       = turn_q;
  assign move_err   = err_q;
`else
  logic unused_move;

  assign move_ready  = 1'b0;
  assign turn        = 1'b0;
  assign move_err    = 1'b0;
  assign unused_move = ^{move_valid, move_row, move_col};
`endif

  always_comb begin
    state_d = state_q;
    board_d = board_q;
    wrote   = 1'b0;
`ifdef GAME_MOVE_APPLY_EN
    turn_d  = turn_q;
    err_d   = 1'b0;
    row_d   = row_q;
    col_d   = col_q;
`endif
    unique case (state_q)
      SELF: begin
        board_d = preset;
        if (comm_sel) begin
          state_d = RX_WAIT;
        end
      end
      RX_WAIT: begin
        if (rx_valid) begin
          board_d = board_in;
          wrote   = 1'b1;
        end
        if (!comm_sel) begin
          state_d = SELF;
        end
`ifdef GAME_MOVE_APPLY_EN
        else if (move_valid && move_ready) begin
          row_d   = move_row;
          col_d   = move_col;
          state_d = MOVE_CHK;
        end
`endif
      end
`ifdef GAME_MOVE_APPLY_EN
      MOVE_CHK: begin
        if (legal) begin
          state_d = MOVE_WR;
        end else begin
          err_d   = 1'b1;
          state_d = comm_sel ? RX_WAIT : SELF;
        end
      end
      MOVE_WR: begin
        board_d[cell_lsb(int'(row_q), int'(col_q), N) +: 2] =
          turn_q ? WHITE : BLACK;
        turn_d  = ~turn_q;
        wrote   = 1'b1;
        state_d = comm_sel ? RX_WAIT : SELF;
      end
`endif
      default: state_d = SELF;
    endcase
    // The preset overwrites the board in SELF, so no pulse there.
    upd_d = wrote && (state_d != SELF);
  end

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      state_q <= SELF;
      board_q <= '0;
      upd_q   <= 1'b0;
`ifdef GAME_MOVE_APPLY_EN
      turn_q  <= 1'b0;
      err_q   <= 1'b0;
      row_q   <= '0;
      col_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      board_q <= board_d;
      upd_q   <= upd_d;
`ifdef GAME_MOVE_APPLY_EN
      turn_q  <= turn_d;
      err_q   <= err_d;
      row_q   <= row_d;
      col_q   <= col_d;
`endif
    end
  end

endmodule

// File: tb/tb_board_keeper.sv
// Randomized bench for board_keeper with an array-level board model.
// Move checks follow GAME_MOVE_APPLY_EN.
module tb_board_keeper;

  localparam int N  = 9;
  localparam int NP = 3;
  localparam int BW = 2 * N * N;
`ifdef GAME_MOVE_APPLY_EN
  localparam bit MOVES = 1'b1;
`else
  localparam bit MOVES = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          comm_sel;
  logic [1:0]    preset_sel;
  logic          rx_valid;
  logic          rx_ready;
  logic [BW-1:0] board_in;
  logic          move_valid;
  logic          move_ready;
  logic [3:0]    move_row;
  logic [3:0]    move_col;
  logic [BW-1:0] board;
  logic          turn;
  logic          board_update;
  logic          move_err;

  board_keeper #(
    .N          (N),
    .NUM_PRESETS(NP)
  ) dut (
    .clk_in      (clk),
    .reset       (reset),
    .comm_sel    (comm_sel),
    .preset_sel  (preset_sel),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .board_in    (board_in),
    .move_valid  (move_valid),
    .move_ready  (move_ready),
    .move_row    (move_row),
    .move_col    (move_col),
    .board       (board),
    .turn        (turn),
    .board_update(board_update),
    .move_err    (move_err)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  bit chk_on = 1'b0;

  // Model: board as a 2-D array plus "online" and a move stage count.
  int mb [N][N];
  bit online;
  int stage;
  int mr;
  int mc;
  bit mturn;
  bit mupd;
  bit merr;

  function automatic int preset_stone(int idx, int r, int c);
    if (idx == 0) begin
      if (r < 2 && c < 2) return (r + c == 0) ? 2 : 1;
      if (r >= N - 2 && c >= N - 2) return 2;
      return 0;
    end
    if (idx == 1) begin
      if ((r == 0 || r == N - 1) && (c == 0 || c == N - 1)) return 1;
      if (r == N / 2 && c == N / 2) return 2;
      return 0;
    end
    return 0;
  endfunction

  function automatic logic [BW-1:0] pack_model();
    logic [BW-1:0] v;
    v = '0;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        v[2*(r*N+c) +: 2] = 2'(mb[r][c]);
    return v;
  endfunction

  function automatic logic [1:0] cell_of(int r, int c);
    return board[2*(r*N+c) +: 2];
  endfunction

  task automatic model_reset();
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        mb[r][c] = 0;
    online = 1'b0;
    stage  = 0;
    mturn  = 1'b0;
    mupd   = 1'b0;
    merr   = 1'b0;
  endtask

  task automatic model_step();
    mupd = 1'b0;
    merr = 1'b0;
    if (!online) begin
      for (int r = 0; r < N; r++)
        for (int c = 0; c < N; c++)
          mb[r][c] = preset_stone(int'(preset_sel), r, c);
      online = comm_sel;
    end else if (stage == 0) begin
      if (rx_valid) begin
        for (int r = 0; r < N; r++)
          for (int c = 0; c < N; c++)
            mb[r][c] = int'(board_in[2*(r*N+c) +: 2]);
        mupd = comm_sel;
      end
      if (!comm_sel) begin
        online = 1'b0;
      end else if (MOVES && move_valid && !rx_valid) begin
        mr    = int'(move_row);
        mc    = int'(move_col);
        stage = 1;
      end
    end else if (stage == 1) begin
      if (mr < N && mc < N && mb[mr][mc] == 0) begin
        stage = 2;
      end else begin
        merr   = 1'b1;
        stage  = 0;
        online = comm_sel;
      end
    end else begin
      mb[mr][mc] = mturn ? 2 : 1;
      mturn      = !mturn;
      stage      = 0;
      mupd       = comm_sel;
      online     = comm_sel;
    end
  endtask

  task automatic check_bit(input string nm, input logic got, input logic exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic check_vec(input string nm, input logic [BW-1:0] got,
                           input logic [BW-1:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic check_cell(input string nm, input int r, input int c,
                            input logic [1:0] exp);
    tests++;
    if (cell_of(r, c) !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b", nm, cell_of(r, c), exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      check_bit("rx_ready", rx_ready, online && stage == 0);
      check_bit("move_ready", move_ready,
                MOVES && online && stage == 0 && comm_sel && !rx_valid);
      check_vec("board", board, pack_model());
      check_bit("turn", turn, mturn);
      check_bit("board_update", board_update, mupd);
      check_bit("move_err", move_err, merr);
    end
  end

  task automatic cycle();
    @(negedge clk);
    @(posedge clk);
    if (!reset) model_reset();
    else model_step();
    #1;
  endtask

  task automatic do_move(input int r, input int c);
    move_valid = 1'b1;
    move_row   = 4'(r);
    move_col   = 4'(c);
    cycle();
    move_valid = 1'b0;
    cycle();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    logic [BW-1:0] tmp;
    reset      = 1'b1;
    comm_sel   = 1'b0;
    preset_sel = 2'd0;
    rx_valid   = 1'b0;
    board_in   = '0;
    move_valid = 1'b0;
    move_row   = '0;
    move_col   = '0;
    model_reset();
    #2 reset = 1'b0;
    #1;
    check_vec("rst_board", board, '0);
    check_bit("rst_turn", turn, 1'b0);
    check_bit("rst_rx_ready", rx_ready, 1'b0);
    check_bit("rst_move_ready", move_ready, 1'b0);
    check_bit("rst_update", board_update, 1'b0);
    check_bit("rst_err", move_err, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk_on = 1'b1;
    reset  = 1'b1;

    cycle();
    check_cell("p0_00", 0, 0, 2'b10);
    check_cell("p0_01", 0, 1, 2'b01);
    check_cell("p0_11", 1, 1, 2'b01);
    check_cell("p0_88", 8, 8, 2'b10);
    check_cell("p0_77", 7, 7, 2'b10);
    check_cell("p0_44", 4, 4, 2'b00);
    check_bit("p0_rx_ready", rx_ready, 1'b0);

    preset_sel = 2'd1;
    cycle();
    check_cell("p1_08", 0, 8, 2'b01);
    check_cell("p1_44", 4, 4, 2'b10);
    preset_sel = 2'd3;
    cycle();
    check_vec("psel_oob", board, '0);

    preset_sel = 2'd0;
    comm_sel   = 1'b1;
    cycle();
    rx_valid = 1'b1;
    board_in = {N*N{2'b10}};
    cycle();
    check_vec("rx_white", board, {N*N{2'b10}});
    check_bit("rx_update", board_update, 1'b1);
    check_bit("rx_turn", turn, 1'b0);
    rx_valid = 1'b0;
    cycle();
    check_bit("rx_update_drop", board_update, 1'b0);
    rx_valid = 1'b1;
    board_in = '0;
    cycle();
    rx_valid = 1'b0;

`ifdef GAME_MOVE_APPLY_EN
    do_move(4, 4);
    cycle();
    check_cell("mv44", 4, 4, 2'b01);
    check_bit("mv44_turn", turn, 1'b1);
    check_bit("mv44_update", board_update, 1'b1);
    do_move(4, 5);
    cycle();
    check_cell("mv45", 4, 5, 2'b10);
    check_bit("mv45_turn", turn, 1'b0);
    do_move(4, 4);
    check_bit("dup_err", move_err, 1'b1);
    check_cell("dup_cell", 4, 4, 2'b01);
    check_bit("dup_turn", turn, 1'b0);
    check_bit("dup_ready", move_ready, 1'b1);
    cycle();
    check_bit("dup_err_drop", move_err, 1'b0);
    do_move(9, 0);
    check_bit("oob_err", move_err, 1'b1);
    cycle();

    tmp        = '0;
    tmp[1:0]   = 2'b01;
    board_in   = tmp;
    rx_valid   = 1'b1;
    move_valid = 1'b1;
    move_row   = 4'd6;
    move_col   = 4'd6;
    #1;
    check_bit("both_move_ready", move_ready, 1'b0);
    cycle();
    check_vec("both_board", board, tmp);
    check_bit("both_rx_ready", rx_ready, 1'b1);
    rx_valid   = 1'b0;
    move_valid = 1'b0;
    cycle();
    check_cell("both_no_move", 6, 6, 2'b00);

    move_valid = 1'b1;
    move_row   = 4'd2;
    move_col   = 4'd2;
    cycle();
    move_valid = 1'b0;
    comm_sel   = 1'b0;
    cycle();
    cycle();
    check_cell("drop_cell", 2, 2, 2'b01);
    check_bit("drop_turn", turn, 1'b1);
    check_bit("drop_rx_ready", rx_ready, 1'b0);
    check_bit("drop_update", board_update, 1'b0);
    cycle();
    check_cell("drop_preset", 0, 0, 2'b10);

    comm_sel = 1'b1;
    cycle();
    do_move(3, 3);
    reset = 1'b0;
    model_reset();
    #1;
    check_vec("wr_rst_board", board, '0);
    check_bit("wr_rst_turn", turn, 1'b0);
    check_bit("wr_rst_update", board_update, 1'b0);
    check_bit("wr_rst_err", move_err, 1'b0);
    check_bit("wr_rst_rx_ready", rx_ready, 1'b0);
    cycle();
`endif

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        reset = 1'b0;
        model_reset();
      end else begin
        reset = 1'b1;
      end
      comm_sel   = $urandom_range(0, 9) != 0;
      preset_sel = 2'($urandom_range(0, 3));
      rx_valid   = $urandom_range(0, 4) == 0;
      for (int k = 0; k < N * N; k++)
        board_in[2*k +: 2] = ($urandom_range(0, 9) < 7) ?
                             2'b00 : 2'($urandom_range(1, 3));
      move_valid = $urandom_range(0, 1) == 1;
      move_row   = ($urandom_range(0, 7) == 0) ?
                   4'($urandom_range(9, 15)) : 4'($urandom_range(0, 8));
      move_col   = ($urandom_range(0, 7) == 0) ?
                   4'($urandom_range(9, 15)) : 4'($urandom_range(0, 8));
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
